// File: rtl/package_settings.sv
// Shared settings for the ADC channel chain: sample width, the pulse event
// record handed from the peak detector to readout, and the detector FSM states.
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int EV_TIME_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } pd_state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amplitude;
        logic        [EV_TIME_W-1:0]        tstamp;
        logic        [7:0]                  width;
        logic                               pileup;
    } event_t;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO of pulse events. The head entry is read straight out
// of the storage registers, so a pushed event is visible the cycle after the
// push and the next entry follows a pop without a bubble.
module event_fifo
    import package_settings::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  event_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output event_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    event_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; a pop frees the slot a same-cycle push needs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/filter_peak_detector.sv
// Turns the trapezoidal filter output into pulse events (peak, peak time,
// over-threshold width, pile-up) and queues them for readout.
module filter_peak_detector
    import package_settings::*;
#(
    parameter int THRESHOLD  = 16,
    parameter int HOLDOFF    = 8,
    parameter int MAX_WIDTH  = 64,
    parameter int TIME_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic                               ev_ready,
    output logic                               ev_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_amplitude,
    output logic        [TIME_W-1:0]           ev_time,
    output logic        [7:0]                  ev_width,
    output logic                               ev_pileup,
    output logic        [15:0]                 drop_count
);

    localparam logic signed [SIZE_FILTER_DATA-1:0] THR = SIZE_FILTER_DATA'(THRESHOLD);
    localparam logic [7:0] HOLD_LAST = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

    pd_state_t                          state;
    logic        [TIME_W-1:0]           tstamp;
    logic signed [SIZE_FILTER_DATA-1:0] peak;
    logic        [TIME_W-1:0]           peak_time;
    logic        [7:0]                  width;
    logic        [7:0]                  hold_cnt;

    logic                               over;
    logic        [7:0]                  width_next;
    logic                               ev_close;
    event_t                             close_data;
    logic                               pop;
    logic                               fifo_full;
    logic                               fifo_empty;
    event_t                             head;

    // Decide whether the current sample closes an event and build its record.
    always_comb begin
        over       = input_data > THR;
        width_next = sat_inc8(width);
        ev_close   = 1'b0;
        close_data = '0;
        case (state)
            IDLE: begin
                if (over && MAX_WIDTH <= 1) begin
                    ev_close             = 1'b1;
                    close_data.amplitude = input_data;
                    close_data.tstamp    = EV_TIME_W'(tstamp);
                    close_data.width     = 8'd1;
                    close_data.pileup    = 1'b1;
                end
            end
            TRACK: begin
                if (!over) begin
                    ev_close             = 1'b1;
                    close_data.amplitude = peak;
                    close_data.tstamp    = EV_TIME_W'(peak_time);
                    close_data.width     = width;
                    close_data.pileup    = 1'b0;
                end else if (int'(width_next) >= MAX_WIDTH) begin
                    ev_close             = 1'b1;
                    close_data.amplitude = (input_data > peak) ? input_data : peak;
                    close_data.tstamp    = EV_TIME_W'((input_data > peak) ? tstamp : peak_time);
                    close_data.width     = width_next;
                    close_data.pileup    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Free-running timestamp; every sample is tagged with the count of its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tstamp <= '0;
        end else begin
            tstamp <= tstamp + TIME_W'(1);
        end
    end

    // Event FSM: track peak and width while over threshold, then sit out the holdoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            peak      <= '0;
            peak_time <= '0;
            width     <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (over) begin
                        peak      <= input_data;
                        peak_time <= tstamp;
                        width     <= 8'd1;
                        state     <= TRACK;
                    end
                end
                TRACK: begin
                    if (over) begin
                        width <= width_next;
                        if (input_data > peak) begin
                            peak      <= input_data;
                            peak_time <= tstamp;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ev_close) begin
                hold_cnt <= HOLD_LAST;
                state    <= (HOLDOFF > 0) ? HOLD : IDLE;
            end
        end
    end

    // Count events that arrive while the buffer is full and nothing is leaving.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (ev_close && fifo_full && !pop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign pop = ev_valid && ev_ready;

    event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_close),
        .push_data (close_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign ev_valid     = !fifo_empty;
    assign ev_amplitude = head.amplitude;
    assign ev_time      = TIME_W'(head.tstamp);
    assign ev_width     = head.width;
    assign ev_pileup    = head.pileup;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Scenario bench for filter_peak_detector: expected events are queued as the
// pulses are driven, and a monitor collects every accepted event for comparison.
module tb_filter_peak_detector;
    import package_settings::*;

    localparam int HOLDOFF = 8;

    typedef struct packed {
        logic signed [15:0] amp;
        logic        [15:0] t;
        logic        [7:0]  w;
        logic               p;
    } ev_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] input_data = '0;
    logic               ev_ready = 1'b0;
    logic               ev_valid;
    logic signed [15:0] ev_amplitude;
    logic        [15:0] ev_time;
    logic        [7:0]  ev_width;
    logic               ev_pileup;
    logic        [15:0] drop_count;

    int          checks = 0;
    int          failures = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [15:0] t_now = '0;

    filter_peak_detector #(
        .THRESHOLD (16),
        .HOLDOFF   (HOLDOFF),
        .MAX_WIDTH (64),
        .TIME_W    (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .ev_ready    (ev_ready),
        .ev_valid    (ev_valid),
        .ev_amplitude(ev_amplitude),
        .ev_time     (ev_time),
        .ev_width    (ev_width),
        .ev_pileup   (ev_pileup),
        .drop_count  (drop_count)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Record every event the consumer accepts, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            obs_q.push_back({ev_amplitude, ev_time, ev_width, ev_pileup});
        end
    end

    // Hold reset for three edges; the cycle right after release carries a zero sample at time 0.
    task automatic do_reset();
        reset = 1'b1;
        ev_ready = 1'b0;
        input_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        t_now = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Present one sample in the next cycle and advance the bench's time model.
    task automatic apply_sample(input logic signed [15:0] v);
        @(posedge clk);
        #1;
        input_data = v;
        t_now = t_now + 16'd1;
    endtask

    // Three-sample pulse around amp, the closing sample, then the full holdoff.
    task automatic send_pulse(input logic signed [15:0] amp, output logic [15:0] pk_t);
        apply_sample(16'sd25);
        apply_sample(amp);
        pk_t = t_now;
        apply_sample(16'sd25);
        apply_sample(16'sd0);
        repeat (HOLDOFF) apply_sample(16'sd0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b want 0", ev_valid); end
        checks++; if (ev_amplitude !== 16'sd0) begin failures++; $display("[TB] FAIL reset_amp: got %0d want 0", ev_amplitude); end
        checks++; if (ev_time !== 16'd0) begin failures++; $display("[TB] FAIL reset_time: got %0d want 0", ev_time); end
        checks++; if (ev_width !== 8'd0) begin failures++; $display("[TB] FAIL reset_width: got %0d want 0", ev_width); end
        checks++; if (ev_pileup !== 1'b0) begin failures++; $display("[TB] FAIL reset_pileup: got %0b want 0", ev_pileup); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_drops: got %0d want 0", drop_count); end
    endtask

    task automatic test_single_pulse();
        int   wait_cnt;
        ev_t  e;
        ev_t  o;
        do_reset();
        exp_q.push_back({16'sd80, 16'd3, 8'd5, 1'b0});
        apply_sample(16'sd20);
        apply_sample(16'sd50);
        apply_sample(16'sd80);
        apply_sample(16'sd80);
        apply_sample(16'sd40);
        apply_sample(16'sd10);
        @(negedge clk);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_early: got %0b want 0", ev_valid); end
        apply_sample(16'sd0);
        @(negedge clk);
        checks++; if (ev_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid_rise: got %0b want 1", ev_valid); end
        @(posedge clk); #1; ev_ready = 1'b1;
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL single_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL single_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_threshold_edge();
        int   wait_cnt;
        ev_t  e;
        ev_t  o;
        do_reset();
        ev_ready = 1'b1;
        apply_sample(16'sd16);
        apply_sample(16'sd16);
        apply_sample(-16'sd5);
        apply_sample(16'sd17);
        exp_q.push_back({16'sd17, t_now, 8'd1, 1'b0});
        apply_sample(16'sd16);
        repeat (12) apply_sample(16'sd0);
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL thresh_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL thresh_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_long_pulse();
        int   wait_cnt;
        ev_t  e;
        ev_t  o;
        do_reset();
        ev_ready = 1'b1;
        exp_q.push_back({16'sd100, 16'd1, 8'd64, 1'b1});
        for (int i = 0; i < 70; i++) apply_sample(16'sd100);
        repeat (12) apply_sample(16'sd0);
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL long_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL long_drops: got %0d want 0", drop_count); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL long_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_holdoff();
        int   wait_cnt;
        ev_t  e;
        ev_t  o;
        do_reset();
        ev_ready = 1'b1;
        exp_q.push_back({16'sd60, 16'd2, 8'd3, 1'b0});
        apply_sample(16'sd30);
        apply_sample(16'sd60);
        apply_sample(16'sd30);
        apply_sample(16'sd0);
        repeat (4) apply_sample(16'sd0);
        apply_sample(16'sd50);
        apply_sample(16'sd50);
        apply_sample(16'sd0);
        apply_sample(16'sd0);
        apply_sample(16'sd40);
        apply_sample(16'sd70);
        exp_q.push_back({16'sd70, t_now, 8'd3, 1'b0});
        apply_sample(16'sd40);
        apply_sample(16'sd0);
        repeat (12) apply_sample(16'sd0);
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL holdoff_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL holdoff_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_back_pressure();
        int          wait_cnt;
        ev_t         e;
        ev_t         o;
        logic [15:0] pk;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_pulse(16'(30 + 10 * i), pk);
            if (i < 4) exp_q.push_back({16'(30 + 10 * i), pk, 8'd3, 1'b0});
        end
        @(negedge clk);
        checks++; if (drop_count !== 16'd2) begin failures++; $display("[TB] FAIL bp_drops: got %0d want 2", drop_count); end
        checks++; if (ev_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_held: got %0b want 1", ev_valid); end
        checks++; if (ev_amplitude !== 16'sd30) begin failures++; $display("[TB] FAIL bp_head_held: got %0d want 30", ev_amplitude); end
        @(posedge clk); #1; ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (ev_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_drain_%0d: got valid %0b want 1", k, ev_valid); end
        end
        @(negedge clk);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain_empty: got valid %0b want 0", ev_valid); end
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL bp_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL bp_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_full_push_pop();
        int          wait_cnt;
        ev_t         e;
        ev_t         o;
        logic [15:0] pk;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_pulse(16'(50 + 10 * i), pk);
            exp_q.push_back({16'(50 + 10 * i), pk, 8'd3, 1'b0});
        end
        apply_sample(16'sd25);
        apply_sample(16'sd95);
        pk = t_now;
        apply_sample(16'sd25);
        @(posedge clk); #1; input_data = 16'sd0; ev_ready = 1'b1; t_now = t_now + 16'd1;
        exp_q.push_back({16'sd95, pk, 8'd3, 1'b0});
        @(posedge clk); #1; input_data = 16'sd0; ev_ready = 1'b0; t_now = t_now + 16'd1;
        repeat (HOLDOFF) apply_sample(16'sd0);
        @(negedge clk);
        checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL fpp_no_drop: got %0d want 0", drop_count); end
        checks++; if (ev_valid !== 1'b1) begin failures++; $display("[TB] FAIL fpp_valid: got %0b want 1", ev_valid); end
        send_pulse(16'sd99, pk);
        @(negedge clk);
        checks++; if (drop_count !== 16'd1) begin failures++; $display("[TB] FAIL fpp_still_full: got drops %0d want 1", drop_count); end
        @(posedge clk); #1; ev_ready = 1'b1;
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL fpp_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL fpp_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    task automatic test_reset_mid_track();
        int          wait_cnt;
        ev_t         e;
        ev_t         o;
        logic [15:0] pk;
        do_reset();
        for (int i = 0; i < 5; i++) send_pulse(16'(40 + 5 * i), pk);
        @(negedge clk);
        checks++; if (drop_count !== 16'd1) begin failures++; $display("[TB] FAIL rst_pre_drops: got %0d want 1", drop_count); end
        apply_sample(16'sd25);
        @(posedge clk); #1; input_data = 16'sd90; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; input_data = 16'sd0; t_now = '0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %0b want 0", ev_valid); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_drops: got %0d want 0", drop_count); end
        checks++; if (ev_amplitude !== 16'sd0) begin failures++; $display("[TB] FAIL rst_amp: got %0d want 0", ev_amplitude); end
        apply_sample(16'sd40);
        ev_ready = 1'b1;
        exp_q.push_back({16'sd40, t_now, 8'd1, 1'b0});
        apply_sample(16'sd0);
        repeat (12) apply_sample(16'sd0);
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rst_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("[TB] FAIL rst_event: got amp=%0d t=%0d w=%0d p=%0b want amp=%0d t=%0d w=%0d p=%0b", o.amp, o.t, o.w, o.p, e.amp, e.t, e.w, e.p); end
        end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting filter_peak_detector scenarios");
        test_reset();
        test_single_pulse();
        test_threshold_edge();
        test_long_pulse();
        test_holdoff();
        test_back_pressure();
        test_full_push_pop();
        test_reset_mid_track();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
